// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: owns the single register-file write port. The pipeline
// writeback always wins. Long-latency unit (lu) results either bypass straight
// to the port or wait in a small in-order pending-write buffer.
//
// Handshake: an lu request transfers on a rising clk edge where lu_valid and
// lu_ready are both high. lu_ready depends only on registered state, so it
// never depends on lu_valid in the same cycle.
//
// The buffer is a circular array with a head pointer that counts modulo DEPTH.
// Entries that are killed by a newer pipeline write are removed in the same
// cycle. The survivors are re-packed behind the head, so every slot between
// head and head+cnt always holds a live entry. Because of this, the head is
// always the oldest valid write and pend_cnt equals the occupancy.
// DEPTH must be 2 or 4.
module wb_port_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        lu_valid,
    input  logic [4:0]  lu_addr,
    input  logic [31:0] lu_data,
    output logic        lu_ready,
    output logic        rf_we,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    input  logic [4:0]  q_addr,
    output logic        q_hit,
    output logic [2:0]  pend_cnt
);

    localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0] DEPTH_C = 3'(DEPTH);

    logic [4:0]       buf_addr_q [DEPTH];
    logic [31:0]      buf_data_q [DEPTH];
    logic [4:0]       buf_addr_d [DEPTH];
    logic [31:0]      buf_data_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [2:0]       cnt_q, cnt_d;

    logic             pipe_go, lu_acc, lu_live, pop, bypass, push;
    logic             grant;
    logic [4:0]       gnt_addr;
    logic [31:0]      gnt_data;
    logic [PTR_W-1:0] idx, slot, q_idx;
    logic [2:0]       kept;

    assign lu_ready = (cnt_q < DEPTH_C);
    assign pend_cnt = cnt_q;

    // Grant selection: pipeline, then buffer head, then lu bypass; address 0 never writes
    always_comb begin
        pipe_go  = pipe_we && (pipe_addr != 5'd0);
        lu_acc   = lu_valid && lu_ready;
        lu_live  = lu_acc && (lu_addr != 5'd0) && !(pipe_go && (lu_addr == pipe_addr));
        pop      = !pipe_go && (cnt_q != 3'd0);
        bypass   = lu_live && !pipe_go && (cnt_q == 3'd0);
        push     = lu_live && !bypass;
        grant    = 1'b0;
        gnt_addr = 5'd0;
        gnt_data = 32'd0;
        if (pipe_go) begin
            grant    = 1'b1;
            gnt_addr = pipe_addr;
            gnt_data = pipe_data;
        end else if (pop) begin
            grant    = 1'b1;
            gnt_addr = buf_addr_q[head_q];
            gnt_data = buf_data_q[head_q];
        end else if (bypass) begin
            grant    = 1'b1;
            gnt_addr = lu_addr;
            gnt_data = lu_data;
        end
    end

    // Next buffer contents: drop the popped head and entries overwritten by the pipeline, re-pack, append push
    always_comb begin
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
        head_d     = head_q + PTR_W'(pop);
        kept       = 3'd0;
        idx        = '0;
        slot       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head_q + PTR_W'(k);
            if ((3'(k) < cnt_q) && !((k == 0) && pop) &&
                !(pipe_go && (buf_addr_q[idx] == pipe_addr))) begin
                slot             = head_d + kept[PTR_W-1:0];
                buf_addr_d[slot] = buf_addr_q[idx];
                buf_data_d[slot] = buf_data_q[idx];
                kept             = kept + 3'd1;
            end
        end
        if (push) begin
            slot             = head_d + kept[PTR_W-1:0];
            buf_addr_d[slot] = lu_addr;
            buf_data_d[slot] = lu_data;
        end
        cnt_d = kept + {2'b00, push};
    end

    // Hazard query: any live pending entry, or an lu request being pushed this cycle
    always_comb begin
        q_hit = 1'b0;
        q_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            q_idx = head_q + PTR_W'(k);
            if ((3'(k) < cnt_q) && (buf_addr_q[q_idx] == q_addr)) begin
                q_hit = 1'b1;
            end
        end
        if (push && (lu_addr == q_addr)) begin
            q_hit = 1'b1;
        end
        if (q_addr == 5'd0) begin
            q_hit = 1'b0;
        end
    end

    // Buffer storage, head pointer and occupancy
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                buf_addr_q[k] <= 5'd0;
                buf_data_q[k] <= 32'd0;
            end
            head_q <= '0;
            cnt_q  <= 3'd0;
        end else begin
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
            head_q     <= head_d;
            cnt_q      <= cnt_d;
        end
    end

    // Register-file write port, one cycle after the grant
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we   <= 1'b0;
            rf_addr <= 5'd0;
            rf_data <= 32'd0;
        end else begin
            rf_we   <= grant;
            rf_addr <= gnt_addr;
            rf_data <= gnt_data;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (DEPTH = 2). Expected register-file
// writes are queued as stimulus is driven and consumed by a monitor that
// watches rf_we on the falling edge.
module tb_wb_port_arbiter;

  logic        clk;
  logic        reset;
  logic        pipe_we;
  logic [4:0]  pipe_addr;
  logic [31:0] pipe_data;
  logic        lu_valid;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [4:0]  q_addr;
  logic        q_hit;
  logic [2:0]  pend_cnt;

  int n_vec = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  wb_port_arbiter #(.DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .pipe_we(pipe_we), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data),
    .q_addr(q_addr), .q_hit(q_hit), .pend_cnt(pend_cnt)
  );

  // clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic idle();
    pipe_we = 1'b0; pipe_addr = 5'd0; pipe_data = 32'd0;
    lu_valid = 1'b0; lu_addr = 5'd0; lu_data = 32'd0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      if (rf_we !== 1'b0) check_val("rf_we_in_reset", 64'(rf_we), 64'd0);
    end else if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("spurious_wr", 64'({rf_addr, rf_data}), 64'd0);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        check_val("rf_wr", 64'({rf_addr, rf_data}), 64'(e));
      end
    end
  end

  // pipe held on r1 for 4 cycles with lu traffic; optional kill of head (1) or tail (2) entry
  task automatic fill_drain(input int kill);
    logic [4:0]  a0, a1, ka;
    logic [31:0] d0, d1;
    int          remain;
    a0 = 5'($urandom_range(2, 15));
    a1 = 5'($urandom_range(16, 31));
    d0 = $urandom;
    d1 = $urandom;
    q_addr = a0;
    for (int i = 0; i < 4; i++) begin
      pipe_we = 1'b1; pipe_addr = 5'd1; pipe_data = $urandom;
      expect_wr(5'd1, pipe_data);
      lu_valid = 1'b1;
      if (i == 0) begin lu_addr = a0; lu_data = d0; end
      else if (i == 1) begin lu_addr = a1; lu_data = d1; end
      else begin lu_addr = 5'd4; lu_data = 32'hDEAD0000; end
      @(negedge clk);
      check_val("fd_lu_ready", 64'(lu_ready), (i < 2) ? 64'd1 : 64'd0);
      check_val("fd_pend", 64'(pend_cnt), (i < 2) ? 64'(i) : 64'd2);
      check_val("fd_q_hit", 64'(q_hit), 64'd1);
      next();
    end
    remain = 2;
    if (kill != 0) begin
      ka = (kill == 1) ? a0 : a1;
      idle();
      pipe_we = 1'b1; pipe_addr = ka; pipe_data = $urandom;
      expect_wr(ka, pipe_data);
      @(negedge clk);
      check_val("fd_kill_q_hit", 64'(q_hit), 64'd1);
      next();
      remain = 1;
    end
    idle();
    if (kill != 1) expect_wr(a0, d0);
    if (kill != 2) expect_wr(a1, d1);
    @(negedge clk);
    check_val("fd_drain_pend", 64'(pend_cnt), 64'(remain));
    check_val("fd_drain_ready", 64'(lu_ready), (remain < 2) ? 64'd1 : 64'd0);
    repeat (3) next();
    @(negedge clk);
    check_val("fd_end_pend", 64'(pend_cnt), 64'd0);
    check_val("fd_end_q_hit", 64'(q_hit), 64'd0);
    next();
  endtask

  // main sequence
  initial begin
    logic [31:0] pd;
    reset = 1'b1;
    idle();
    q_addr = 5'd0;
    repeat (2) @(negedge clk);
    check_val("rst_rf_we", 64'(rf_we), 64'd0);
    check_val("rst_rf_addr", 64'(rf_addr), 64'd0);
    check_val("rst_rf_data", 64'(rf_data), 64'd0);
    check_val("rst_pend", 64'(pend_cnt), 64'd0);
    check_val("rst_lu_ready", 64'(lu_ready), 64'd1);
    #1 reset = 1'b0;
    next();

    // lu request into an idle arbiter bypasses straight to the port
    lu_valid = 1'b1; lu_addr = 5'd5; lu_data = 32'hA5A5A5A5; q_addr = 5'd5;
    expect_wr(5'd5, 32'hA5A5A5A5);
    @(negedge clk);
    check_val("byp_lu_ready", 64'(lu_ready), 64'd1);
    check_val("byp_q_hit", 64'(q_hit), 64'd0);
    next();
    idle();
    @(negedge clk);
    check_val("byp_pend", 64'(pend_cnt), 64'd0);
    next();

    // pipe r3 and lu r7 together: r3 first, r7 from the buffer
    pipe_we = 1'b1; pipe_addr = 5'd3; pipe_data = $urandom;
    lu_valid = 1'b1; lu_addr = 5'd7; lu_data = $urandom; q_addr = 5'd7;
    expect_wr(5'd3, pipe_data);
    expect_wr(5'd7, lu_data);
    @(negedge clk);
    check_val("pair_q_hit_push", 64'(q_hit), 64'd1);
    next();
    idle();
    @(negedge clk);
    check_val("pair_pend1", 64'(pend_cnt), 64'd1);
    check_val("pair_q_hit_buf", 64'(q_hit), 64'd1);
    next();
    @(negedge clk);
    check_val("pair_pend0", 64'(pend_cnt), 64'd0);
    check_val("pair_q_hit_gone", 64'(q_hit), 64'd0);
    next();

    // back-pressure, in-order drain, pointer wrap, head/tail invalidation
    for (int r = 0; r < 3; r++) fill_drain(0);
    fill_drain(1);
    fill_drain(2);

    // r9 pending, then a newer pipe write to r9 replaces it
    pipe_we = 1'b1; pipe_addr = 5'd2; pipe_data = $urandom;
    lu_valid = 1'b1; lu_addr = 5'd9; lu_data = 32'h99999999; q_addr = 5'd9;
    expect_wr(5'd2, pipe_data);
    next();
    idle();
    pipe_we = 1'b1; pipe_addr = 5'd9; pipe_data = 32'h1;
    expect_wr(5'd9, 32'h1);
    @(negedge clk);
    check_val("r9_pend_before", 64'(pend_cnt), 64'd1);
    next();
    idle();
    @(negedge clk);
    check_val("r9_pend_after", 64'(pend_cnt), 64'd0);
    check_val("r9_q_hit_after", 64'(q_hit), 64'd0);
    next();

    // lu request to r0 is accepted and dropped
    lu_valid = 1'b1; lu_addr = 5'd0; lu_data = $urandom; q_addr = 5'd0;
    @(negedge clk);
    check_val("r0_lu_ready", 64'(lu_ready), 64'd1);
    check_val("r0_q_hit", 64'(q_hit), 64'd0);
    next();
    idle();
    @(negedge clk);
    check_val("r0_pend", 64'(pend_cnt), 64'd0);
    next();

    // pipe write to r0 does not hold the port; lu r4 bypasses
    pipe_we = 1'b1; pipe_addr = 5'd0; pipe_data = $urandom;
    lu_valid = 1'b1; lu_addr = 5'd4; lu_data = $urandom;
    expect_wr(5'd4, lu_data);
    next();
    idle();
    @(negedge clk);
    check_val("p0_pend", 64'(pend_cnt), 64'd0);
    next();

    // same-address collision: pipe wins, lu dropped
    pipe_we = 1'b1; pipe_addr = 5'd6; pipe_data = $urandom;
    lu_valid = 1'b1; lu_addr = 5'd6; lu_data = $urandom; q_addr = 5'd6;
    expect_wr(5'd6, pipe_data);
    @(negedge clk);
    check_val("col_q_hit", 64'(q_hit), 64'd0);
    next();
    idle();
    @(negedge clk);
    check_val("col_pend", 64'(pend_cnt), 64'd0);
    next();

    // reset with two pending writes drops them
    for (int i = 0; i < 2; i++) begin
      pd = $urandom;
      pipe_we = 1'b1; pipe_addr = 5'd1; pipe_data = pd;
      lu_valid = 1'b1; lu_addr = 5'(13 + i); lu_data = $urandom;
      expect_wr(5'd1, pd);
      next();
    end
    idle();
    @(negedge clk);
    check_val("mr_pend_full", 64'(pend_cnt), 64'd2);
    #1 reset = 1'b1;
    @(negedge clk);
    check_val("mr_rf_we", 64'(rf_we), 64'd0);
    check_val("mr_pend", 64'(pend_cnt), 64'd0);
    check_val("mr_lu_ready", 64'(lu_ready), 64'd1);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_val("mr_post_rf_we", 64'(rf_we), 64'd0);
    end
    check_val("mr_post_pend", 64'(pend_cnt), 64'd0);

    repeat (3) @(negedge clk);
    check_val("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
